// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period (in clk cycles) of an asynchronous PWM input.
// Optional glitch filter on the synchronised level, enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1 << 24,
  parameter int FILTER_LEN  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] high_count,
  output logic [WIDTH-1:0] period_count,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE_C     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;
  logic                   lvl_s;
  logic                   lvl_d_r;
  logic                   rise_s;
  logic                   fall_s;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [WIDTH-1:0]       cnt_r;
  logic [WIDTH-1:0]       cnt_nxt_s;
  logic [WIDTH-1:0]       cnt_inc_s;
  logic [WIDTH-1:0]       hi_lat_r;
  logic [WIDTH-1:0]       hi_lat_nxt_s;
  logic [WIDTH-1:0]       high_nxt_s;
  logic [WIDTH-1:0]       period_nxt_s;
  logic                   valid_nxt_s;
  logic                   stuck_nxt_s;
  logic                   stuck_level_nxt_s;

  // Input synchroniser; runs regardless of enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign s_s = sync_r[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  logic          f_r;
  logic [FW-1:0] flt_cnt_r;

  // Glitch filter: follow s only after it has disagreed for FILTER_LEN cycles in a row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_r       <= 1'b0;
      flt_cnt_r <= '0;
    end else if (s_s == f_r) begin
      flt_cnt_r <= '0;
    end else if (flt_cnt_r >= FLT_LAST) begin
      f_r       <= s_s;
      flt_cnt_r <= '0;
    end else begin
      flt_cnt_r <= flt_cnt_r + FW'(1'b1);
    end
  end

  assign lvl_s = f_r;
`else
  logic unused_filter_len_s;
  assign unused_filter_len_s = (FILTER_LEN > 0);
  assign lvl_s = s_s;
`endif

  // Previous level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_d_r <= 1'b0;
    end else begin
      lvl_d_r <= lvl_s;
    end
  end

  assign rise_s    = lvl_s & ~lvl_d_r;
  assign fall_s    = ~lvl_s & lvl_d_r;
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + ONE_C);

  // Next-state and measurement update logic
  always_comb begin
    state_nxt_s       = state_r;
    cnt_nxt_s         = cnt_r;
    hi_lat_nxt_s      = hi_lat_r;
    high_nxt_s        = high_count;
    period_nxt_s      = period_count;
    valid_nxt_s       = 1'b0;
    stuck_nxt_s       = stuck;
    stuck_level_nxt_s = stuck_level;
    if (!enable) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            state_nxt_s = ST_HIGH;
            cnt_nxt_s   = ONE_C;
            stuck_nxt_s = 1'b0;
          end else begin
            cnt_nxt_s = '0;
          end
        end
        ST_HIGH: begin
          if (cnt_r >= TIMEOUT_C) begin
            state_nxt_s       = ST_IDLE;
            cnt_nxt_s         = '0;
            stuck_nxt_s       = 1'b1;
            stuck_level_nxt_s = lvl_s;
          end else if (fall_s) begin
            state_nxt_s  = ST_LOW;
            hi_lat_nxt_s = cnt_r;
            cnt_nxt_s    = cnt_inc_s;
          end else begin
            cnt_nxt_s = cnt_inc_s;
          end
        end
        ST_LOW: begin
          if (cnt_r >= TIMEOUT_C) begin
            state_nxt_s       = ST_IDLE;
            cnt_nxt_s         = '0;
            stuck_nxt_s       = 1'b1;
            stuck_level_nxt_s = lvl_s;
          end else if (rise_s) begin
            // Rise closes the period; this cycle already counts as 1 of the next one
            state_nxt_s  = ST_HIGH;
            period_nxt_s = cnt_r;
            high_nxt_s   = hi_lat_r;
            valid_nxt_s  = 1'b1;
            cnt_nxt_s    = ONE_C;
          end else begin
            cnt_nxt_s = cnt_inc_s;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      hi_lat_r     <= '0;
      high_count   <= '0;
      period_count <= '0;
      valid        <= 1'b0;
      stuck        <= 1'b0;
      stuck_level  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      hi_lat_r     <= hi_lat_nxt_s;
      high_count   <= high_nxt_s;
      period_count <= period_nxt_s;
      valid        <= valid_nxt_s;
      stuck        <= stuck_nxt_s;
      stuck_level  <= stuck_level_nxt_s;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus pushes expected (high, period) pairs,
// a negedge monitor pops and compares them on every valid pulse.
module tb_pwm_capture;

  localparam int W   = 16;
  localparam int TMO = 64;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int STUCK_WAIT = 21;
`else
  localparam int STUCK_WAIT = 17;
`endif

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] per;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         pwm_in;
  logic [W-1:0] high_count;
  logic [W-1:0] period_count;
  logic         valid;
  logic         stuck;
  logic         stuck_level;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_valid_cyc = 0;
  bit   restart = 1'b1;
  bit   pend = 1'b0;
  int   pend_hi = 0;
  int   pend_per = 0;
  int   k;

  pwm_capture #(
    .WIDTH       (W),
    .SYNC_STAGES (2),
    .TIMEOUT     (TMO),
    .FILTER_LEN  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .pwm_in       (pwm_in),
    .high_count   (high_count),
    .period_count (period_count),
    .valid        (valid),
    .stuck        (stuck),
    .stuck_level  (stuck_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int hi, input int per);
    exp_t e;
    e.hi  = W'(hi);
    e.per = W'(per);
    exp_q.push_back(e);
  endtask

  // A rising edge closes the pending period, if one is open
  task automatic push_pending();
    if (pend) push_exp(pend_hi, pend_per);
  endtask

  task automatic run_period(input int hi, input int lo);
    push_pending();
    pwm_in = 1'b1;
    repeat (hi) @(negedge clk);
    pwm_in = 1'b0;
    repeat (lo) @(negedge clk);
    pend     = 1'b1;
    pend_hi  = hi;
    pend_per = hi + lo;
  endtask

  task automatic glitch_period(input int hi, input int lo1, input int g, input int lo2);
    push_pending();
    pwm_in = 1'b1;
    repeat (hi) @(negedge clk);
    pwm_in = 1'b0;
    repeat (lo1) @(negedge clk);
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
    push_exp(hi, hi + lo1);
`endif
    pwm_in = 1'b1;
    repeat (g) @(negedge clk);
    pwm_in = 1'b0;
    repeat (lo2) @(negedge clk);
    pend = 1'b1;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    pend_hi  = hi;
    pend_per = hi + lo1 + g + lo2;
`else
    pend_hi  = g;
    pend_per = g + lo2;
`endif
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_high"},   32'(high_count),   32'd0);
    check({tag, "_period"}, 32'(period_count), 32'd0);
    check({tag, "_valid"},  32'(valid),        32'd0);
    check({tag, "_stuck"},  32'(stuck),        32'd0);
    check({tag, "_level"},  32'(stuck_level),  32'd0);
  endtask

  // Monitor: every valid must match the oldest expectation and arrive one period after the last
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got high=%0d period=%0d, expected no valid", high_count, period_count);
      end else begin
        e = exp_q.pop_front();
        check("high_count",   32'(high_count),   32'(e.hi));
        check("period_count", 32'(period_count), 32'(e.per));
        if (!restart) check("valid_interval", 32'(cyc - last_valid_cyc), 32'(e.per));
        restart        = 1'b0;
        last_valid_cyc = cyc;
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Steady 4/12, then a transitional period and 10/6
    for (int i = 0; i < 5; i++) run_period(4, 12);
    run_period(4, 6);
    for (int i = 0; i < 3; i++) run_period(10, 6);

    // Pin stuck high
    push_pending();
    pend   = 1'b0;
    pwm_in = 1'b1;
    repeat (50) @(negedge clk);
    check("stuck_early", 32'(stuck), 32'd0);
    k = 0;
    while (k < 40 && !stuck) begin
      @(negedge clk);
      k++;
    end
    check("stuck_delay",      32'(k),            32'(STUCK_WAIT));
    check("stuck_level_high", 32'(stuck_level),  32'd1);
    check("stuck_held_high",  32'(high_count),   32'd10);
    check("stuck_held_per",   32'(period_count), 32'd16);
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    check("stuck_held_idle", 32'(stuck), 32'd1);
    restart = 1'b1;
    run_period(4, 12);
    check("stuck_cleared", 32'(stuck), 32'd0);
    run_period(4, 12);
    run_period(4, 12);

    // Reset in the middle of a high phase
    push_pending();
    pwm_in = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    #1;
    check_zero_outputs("midreset");
    pend    = 1'b0;
    restart = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) run_period(6, 10);

    // Disable for 40 cycles while the pin keeps toggling
    push_pending();
    pwm_in = 1'b1;
    repeat (6) @(negedge clk);
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);
    enable  = 1'b0;
    pend    = 1'b0;
    restart = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pwm_in = 1'b1;
      repeat (5) @(negedge clk);
      pwm_in = 1'b0;
      repeat (10) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("disabled_high",   32'(high_count),   32'd6);
    check("disabled_period", 32'(period_count), 32'd16);
    check("disabled_stuck",  32'(stuck),        32'd0);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) run_period(5, 9);

`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
    // Single-cycle high pulse
    for (int i = 0; i < 3; i++) run_period(1, 7);
`endif

    // Two-cycle glitch inside the low phase
    glitch_period(4, 5, 2, 5);
    run_period(4, 12);

    // Pin stuck low after a final rise
    push_pending();
    pend   = 1'b0;
    pwm_in = 1'b1;
    repeat (4) @(negedge clk);
    pwm_in = 1'b0;
    k = 0;
    while (k < 120 && !stuck) begin
      @(negedge clk);
      k++;
    end
    check("stuck_low_delay", 32'(k),           32'(STUCK_WAIT + 46));
    check("stuck_low_flag",  32'(stuck),       32'd1);
    check("stuck_level_low", 32'(stuck_level), 32'd0);
    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
